// File: rtl/debounce_pkg.sv
// Shared state encodings and default board timing (50 MHz clock) for the
// push-button debounce/auto-repeat conditioner.
package debounce_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE            = 3'd0;
    localparam state_t ST_CONFIRM_PRESS   = 3'd1;
    localparam state_t ST_PRESSED         = 3'd2;
    localparam state_t ST_REPEAT          = 3'd3;
    localparam state_t ST_CONFIRM_RELEASE = 3'd4;

    // 1 ms debounce, 0.5 s to first repeat, then 10 repeats per second
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
    localparam int unsigned DEF_CNT_WIDTH       = 26;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs, synchronous reset to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/debounce_pulse.sv
// Push-button conditioner: synchronizes and debounces a raw button and emits
// single-cycle enable pulses, with optional auto-repeat while held.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic iButton,
    output logic oPulse,
    output logic oLevel,
    output logic oHeld
);

    localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RP_LAST  = CNT_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 btn_sync;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pulse_q, pulse_d;
    logic                 level_q, level_d;
    logic                 held_q, held_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (iButton),
        .q_o   (btn_sync)
    );

    // State, timer and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            held_q  <= held_d;
        end
    end

    // Next state and timer; a change on the synchronized level beats a terminal count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (btn_sync) begin
                    state_d = ST_CONFIRM_PRESS;
                end
            end
            ST_CONFIRM_PRESS: begin
                if (!btn_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_PRESSED: begin
                if (!btn_sync) begin
                    state_d = ST_CONFIRM_RELEASE;
                    cnt_d   = CNT_ZERO;
                end else if (!REPEAT_EN) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == RD_LAST) begin
                    state_d = ST_REPEAT;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_REPEAT: begin
                if (!btn_sync) begin
                    state_d = ST_CONFIRM_RELEASE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == RP_LAST) begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_CONFIRM_RELEASE: begin
                if (btn_sync) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Registered outputs follow the state being entered
    always_comb begin
        pulse_d = 1'b0;
        level_d = 1'b0;
        held_d  = 1'b0;
        if ((state_q == ST_CONFIRM_PRESS) && (state_d == ST_PRESSED)) begin
            pulse_d = 1'b1;
        end
        if ((state_q == ST_PRESSED) && (state_d == ST_REPEAT)) begin
            pulse_d = 1'b1;
        end
        // A reload while staying in REPEAT marks a period boundary
        if ((state_q == ST_REPEAT) && (state_d == ST_REPEAT) && (cnt_d == CNT_ZERO)) begin
            pulse_d = 1'b1;
        end
        level_d = (state_d == ST_PRESSED) || (state_d == ST_REPEAT) ||
                  (state_d == ST_CONFIRM_RELEASE);
        held_d  = (state_d == ST_REPEAT);
    end

    assign oPulse = pulse_q;
    assign oLevel = level_q;
    assign oHeld  = held_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench: one single-shot instance and one auto-repeat instance share
// the button and reset; each scenario checks outputs cycle by cycle.
module tb_debounce_pulse;
    import debounce_pkg::*;

    logic clock;
    logic reset;
    logic button;
    logic pulse_a, level_a, held_a;
    logic pulse_b, level_b, held_b;

    int total;
    int bad;

    debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1'b0),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5),
        .CNT_WIDTH       (8)
    ) dut_a (
        .clock   (clock),
        .reset   (reset),
        .iButton (button),
        .oPulse  (pulse_a),
        .oLevel  (level_a),
        .oHeld   (held_a)
    );

    debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1'b1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5),
        .CNT_WIDTH       (8)
    ) dut_b (
        .clock   (clock),
        .reset   (reset),
        .iButton (button),
        .oPulse  (pulse_b),
        .oLevel  (level_b),
        .oHeld   (held_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        button = 1'b0;
        for (int i = 0; i < 15; i++) tick();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        button = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({pulse_a, level_a, held_a} !== 3'b000) begin
            bad++;
            $display("FAIL reset_a got=%b exp=000", {pulse_a, level_a, held_a});
        end
        total++;
        if ({pulse_b, level_b, held_b} !== 3'b000) begin
            bad++;
            $display("FAIL reset_b got=%b exp=000", {pulse_b, level_b, held_b});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    // Press at i=0 is sampled at edge 1; pulse appears DEBOUNCE_CYCLES+3 ticks later
    task automatic test_clean_press();
        logic [2:0] exp;
        button = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            exp = {(i == 7), (i >= 7), 1'b0};
            total++;
            if ({pulse_a, level_a, held_a} !== exp) begin
                bad++;
                $display("FAIL clean_press cyc=%0d got=%b exp=%b", i, {pulse_a, level_a, held_a}, exp);
            end
        end
        button = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp = {1'b0, (j < 7), 1'b0};
            total++;
            if ({pulse_a, level_a, held_a} !== exp) begin
                bad++;
                $display("FAIL clean_release cyc=%0d got=%b exp=%b", j, {pulse_a, level_a, held_a}, exp);
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        button = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 3) button = 1'b0;
            total++;
            if ({pulse_a, level_a, pulse_b, level_b} !== 4'b0000) begin
                bad++;
                $display("FAIL glitch cyc=%0d got=%b exp=0000", i, {pulse_a, level_a, pulse_b, level_b});
            end
        end
        total++;
        if (dut_a.state_q !== ST_IDLE) begin
            bad++;
            $display("FAIL glitch_idle got=%0d exp=%0d", dut_a.state_q, ST_IDLE);
        end
        settle();
    endtask

    // Toggles 1,0,1,0,1,0 at i=0..5, stable high from i=6
    task automatic test_bouncy_press();
        logic [1:0] exp;
        int         npulse;
        npulse = 0;
        button = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i < 6) button = ~button;
            else button = 1'b1;
            if (pulse_a) npulse++;
            exp = {(i == 13), (i >= 13)};
            total++;
            if ({pulse_a, level_a} !== exp) begin
                bad++;
                $display("FAIL bouncy cyc=%0d got=%b exp=%b", i, {pulse_a, level_a}, exp);
            end
        end
        total++;
        if (npulse != 1) begin
            bad++;
            $display("FAIL bouncy_count got=%0d exp=1", npulse);
        end
        settle();
    endtask

    // Pulses at 7,17,22,...,42; release driven at i=40 reaches the FSM at edge 43
    task automatic test_auto_repeat();
        logic [2:0] exp;
        logic       ep;
        button = 1'b1;
        for (int i = 1; i <= 55; i++) begin
            tick();
            if (i == 40) button = 1'b0;
            ep  = (i == 7) || ((i >= 17) && (i <= 42) && (((i - 17) % 5) == 0));
            exp = {ep, (i >= 7) && (i <= 46), (i >= 17) && (i <= 42)};
            total++;
            if ({pulse_b, level_b, held_b} !== exp) begin
                bad++;
                $display("FAIL auto_repeat cyc=%0d got=%b exp=%b", i, {pulse_b, level_b, held_b}, exp);
            end
        end
        settle();
    endtask

    // Low at i=9..10 enters CONFIRM_RELEASE at 12, back to PRESSED at 14, repeat at 24
    task automatic test_release_bounce();
        logic [2:0] exp;
        button = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (i == 9) button = 1'b0;
            if (i == 11) button = 1'b1;
            if (i == 30) button = 1'b0;
            exp = {(i == 7) || (i == 24) || (i == 29),
                   (i >= 7) && (i <= 36),
                   (i >= 24) && (i <= 32)};
            total++;
            if ({pulse_b, level_b, held_b} !== exp) begin
                bad++;
                $display("FAIL release_bounce cyc=%0d got=%b exp=%b", i, {pulse_b, level_b, held_b}, exp);
            end
        end
        settle();
    endtask

    // Reset sampled at edges 21..23 with button held; fresh press pulse at 24+6
    task automatic test_reset_mid_repeat();
        logic [2:0] exp;
        button = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (i == 20) reset = 1'b1;
            if (i == 23) reset = 1'b0;
            exp = {(i == 7) || (i == 17) || (i == 30),
                   ((i >= 7) && (i <= 20)) || (i >= 30),
                   (i >= 17) && (i <= 20)};
            total++;
            if ({pulse_b, level_b, held_b} !== exp) begin
                bad++;
                $display("FAIL reset_mid_repeat cyc=%0d got=%b exp=%b", i, {pulse_b, level_b, held_b}, exp);
            end
            if ((i >= 21) && (i <= 23)) begin
                total++;
                if ({pulse_a, level_a, held_a} !== 3'b000) begin
                    bad++;
                    $display("FAIL reset_mid_a cyc=%0d got=%b exp=000", i, {pulse_a, level_a, held_a});
                end
            end
        end
        settle();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        button = 1'b0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bouncy_press();
        test_auto_repeat();
        test_release_bounce();
        test_reset_mid_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Conditions a raw push-button input into clean single-cycle enable pulses for the downstream up-counter's `enable` input.
- Input path: two-flop synchronizer, then a debounce state machine.
- Optional auto-repeat: while the button is held, emits further pulses at a programmable rate.
- Sits between the board button pin and the counter, one instance per counted input.

Parameters:
- DEBOUNCE_CYCLES, 50000, cycles input must stay stable to accept a press/release (>=1)
- REPEAT_EN, 1, 1 enables auto-repeat while held; 0 gives exactly one pulse per press
- REPEAT_DELAY, 25000000, cycles from first pulse to first repeat pulse (>=1)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=1)
- CNT_WIDTH, 26, timer width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)-1

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- iButton  input  1  raw asynchronous button level, active-high
- oPulse  output  1  one-cycle enable pulse to counter
- oLevel  output  1  debounced button level
- oHeld  output  1  high while in auto-repeat

Behaviour:
- Reset/clock: reset reset, synchronous, active-high; clock clock.
- Reset values: synchronizer flops 0, state IDLE, timer 0, oPulse/oLevel/oHeld 0.
- Reset mid-operation: returns to IDLE on the edge where reset is sampled high, regardless of iButton. No pulse is emitted on that edge.
- Synchronizer: s1<=iButton, s2<=s1. The FSM uses only s2 (2-cycle input latency).
- FSM states: IDLE, CONFIRM_PRESS, PRESSED, REPEAT, CONFIRM_RELEASE.
- Single timer `cnt`; every transition below loads cnt=0, otherwise cnt increments.
  - IDLE: s2=1 -> CONFIRM_PRESS.
  - CONFIRM_PRESS:
    - s2=0 -> IDLE (glitch rejected, no pulse).
    - s2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, oPulse=1.
  - PRESSED:
    - s2=0 -> CONFIRM_RELEASE.
    - REPEAT_EN=1 and cnt==REPEAT_DELAY-1 -> REPEAT, oPulse=1.
  - REPEAT:
    - s2=0 -> CONFIRM_RELEASE.
    - cnt==REPEAT_PERIOD-1 -> oPulse=1, cnt=0, stay.
  - CONFIRM_RELEASE:
    - s2=1 -> PRESSED (bounce absorbed, no pulse, repeat delay restarts).
    - s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
- Timer never wraps: every state leaves or reloads before the terminal count.
- Output timing:
  - oPulse is registered, high exactly one cycle, never on two consecutive cycles.
  - oLevel is registered: 1 in PRESSED/REPEAT/CONFIRM_RELEASE, 0 otherwise.
  - oHeld is registered: 1 only in REPEAT.
- Latency: iButton stable high before edge E0 -> oPulse high in the cycle after edge E0+DEBOUNCE_CYCLES+2.
- Release latency: iButton stable low from edge E1 -> oLevel falls after edge E1+DEBOUNCE_CYCLES+2.
- Simultaneous events: a level change on s2 takes priority over a timer terminal count in the same cycle.
- Illegal state encodings -> IDLE.

Decomposition:
- Shared package `debounce_pkg`: state encodings (3-bit localparams ST_IDLE..ST_CONFIRM_RELEASE) and the default timing constants for the 50 MHz board clock.
- One sub-module: `sync_2ff` (2-flop synchronizer with synchronous reset), reusable for other board inputs.
- The FSM, timer and output registers stay in debounce_pulse.

Test Plan:
- Params DEBOUNCE_CYCLES=4, REPEAT_EN=0; clean press at edge 10, held 40 cycles -> single oPulse in cycle after edge 16; oLevel=1 from then until 7 cycles after release.
- Glitch: iButton high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> no oPulse, oLevel stays 0, FSM back in IDLE.
- Bouncy press: 1,0,1,0 toggles every cycle for 6 cycles then stable 1 -> exactly one oPulse, 7 cycles after last rising toggle.
- Auto-repeat: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5; hold 40 cycles -> pulses at P, P+10, P+15, P+20, ...; oHeld=1 from P+10; on release oHeld=0 and no further pulses.
- Release bounce: in PRESSED, iButton low 2 cycles then high -> oLevel stays 1, no pulse; repeat timer restarts (next repeat REPEAT_DELAY cycles after return to PRESSED).
- Reset mid-REPEAT with button held -> outputs 0 after reset edge; after reset release with button still held, new press pulse after DEBOUNCE_CYCLES+2 cycles.
